instr_decode: RTL and testbench

Instruction decode stage of the accumulator core. Takes the 16-bit instruction word and 4-bit `full_operation` opcode from the fetch stage (program counter plus program memory). Produces registered control for the register file, ALU and data memory. Drives the fetch stage's count enable, so it stalls fetch for multi-cycle loads and on halt.

---
 rtl/op_code_pkg.sv | 23 ++
 rtl/instr_decode.sv | 195 +++++++++++++++++++
 tb/tb_instr_decode.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/op_code_pkg.sv
// Shared opcode package: full_operation, LD mode constants and
// the accumulator source select used by decode and execute.
package op_code;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_LD      = 4'h1,
    OP_ST      = 4'h2,
    OP_ADD     = 4'h3,
    OP_XOR_BIT = 4'h4,
    OP_STM     = 4'h5
  } full_operation;

  localparam logic [1:0] DIRECT_LD  = 2'b10;
  localparam logic [1:0] DEFAULT_LD = 2'b00;

  typedef enum logic [1:0] {
    ACC_IMM = 2'd0,
    ACC_MEM = 2'd1,
    ACC_ALU = 2'd2
  } acc_src_t;

endpackage

// File: rtl/instr_decode.sv
// Decode stage of the accumulator core: registered control strobes.
// ID_ILLEGAL_TRAP_EN makes illegal instructions halt until reset.
module instr_decode
  import op_code::*;
#(
  parameter int DM_AW = 10,
  parameter int RF_AW = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [15:0]      i_instr,
  input  full_operation    i_op,
  output logic             o_pc_ce,
  output logic [RF_AW-1:0] o_rf_addr,
  output logic             o_rf_we,
  output logic             o_acc_we,
  output acc_src_t         o_acc_src,
  output logic [7:0]       o_imm,
  output full_operation    o_alu_op,
  output logic [DM_AW-1:0] o_dm_addr,
  output logic             o_dm_re,
  output logic             o_dm_we,
  output logic             o_illegal,
  output logic             o_halt
);

  typedef enum logic [1:0] {
    S_DEC  = 2'd0,
    S_MEMW = 2'd1,
    S_HALT = 2'd2
  } state_t;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  state_t r_state, w_state_nx;

  logic [RF_AW-1:0] r_rf_addr, w_rf_addr;
  logic [DM_AW-1:0] r_dm_addr, w_dm_addr;
  logic [7:0]       r_imm, w_imm;
  full_operation    r_alu_op, w_alu_op;
  acc_src_t         r_acc_src, w_acc_src;
  logic r_rf_we, w_rf_we;
  logic r_acc_we, w_acc_we;
  logic r_dm_re, w_dm_re;
  logic r_dm_we, w_dm_we;
  logic r_illegal;

  full_operation w_op;
  logic [1:0]    w_mode;
  logic          w_in_dec;
  logic          w_mem_ld;
  logic          w_illegal;
  logic          w_stall;

  assign w_op     = full_operation'(i_instr[5:2]);
  assign w_mode   = i_instr[7:6];
  assign w_in_dec = (r_state == S_DEC);
  assign w_mem_ld = (w_op == OP_LD) && (w_mode == DEFAULT_LD);

  always_comb begin
    w_illegal = 1'b0;
    if (w_in_dec) begin
      case (w_op)
        OP_NOP, OP_ST, OP_ADD,
        OP_XOR_BIT, OP_STM: w_illegal = 1'b0;
        OP_LD: w_illegal = (w_mode != DIRECT_LD) &&
                           (w_mode != DEFAULT_LD);
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_stall = w_mem_ld | (TRAP & w_illegal);

  // The stalled LD stays on the bus through S_MEMW; the PC steps past
  // it at the edge that ends S_MEMW, so it advances once per load.
  assign o_pc_ce = i_en &
                   ((w_in_dec & ~w_stall) | (r_state == S_MEMW));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_state <= S_DEC;
    else if (i_en) r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_DEC: begin
        if (w_mem_ld)                w_state_nx = S_MEMW;
        else if (TRAP && w_illegal)  w_state_nx = S_HALT;
      end
      S_MEMW:  w_state_nx = S_DEC;
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_DEC;
    endcase
  end

  always_comb begin
    w_rf_we   = 1'b0;
    w_acc_we  = 1'b0;
    w_dm_re   = 1'b0;
    w_dm_we   = 1'b0;
    w_rf_addr = r_rf_addr;
    w_dm_addr = r_dm_addr;
    w_imm     = r_imm;
    w_alu_op  = r_alu_op;
    w_acc_src = r_acc_src;
    if (w_in_dec && !w_illegal) begin
      case (w_op)
        OP_LD: begin
          if (w_mode == DIRECT_LD) begin
            w_acc_we  = 1'b1;
            w_acc_src = ACC_IMM;
            w_imm     = i_instr[15:8];
          end else begin
            w_dm_re   = 1'b1;
            w_dm_addr = i_instr[6 +: DM_AW];
          end
        end
        OP_ST: begin
          w_rf_we   = 1'b1;
          w_rf_addr = i_instr[0 +: RF_AW];
        end
        OP_ADD, OP_XOR_BIT: begin
          w_alu_op  = i_op;
          w_acc_we  = 1'b1;
          w_acc_src = ACC_ALU;
          w_rf_addr = i_instr[0 +: RF_AW];
        end
        OP_STM: begin
          w_dm_we   = 1'b1;
          w_dm_addr = i_instr[6 +: DM_AW];
        end
        default: ;
      endcase
    end else if (r_state == S_MEMW) begin
      w_acc_we  = 1'b1;
      w_acc_src = ACC_MEM;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rf_we   <= 1'b0;
      r_acc_we  <= 1'b0;
      r_dm_re   <= 1'b0;
      r_dm_we   <= 1'b0;
      r_illegal <= 1'b0;
      r_rf_addr <= '0;
      r_dm_addr <= '0;
      r_imm     <= '0;
      r_alu_op  <= OP_NOP;
      r_acc_src <= ACC_IMM;
    end else if (i_en) begin
      r_rf_we   <= w_rf_we;
      r_acc_we  <= w_acc_we;
      r_dm_re   <= w_dm_re;
      r_dm_we   <= w_dm_we;
      r_illegal <= w_illegal;
      r_rf_addr <= w_rf_addr;
      r_dm_addr <= w_dm_addr;
      r_imm     <= w_imm;
      r_alu_op  <= w_alu_op;
      r_acc_src <= w_acc_src;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic r_halt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_halt <= 1'b0;
    else if (i_en) r_halt <= r_halt | w_illegal;
  end
  assign o_halt = r_halt;
`else
  assign o_halt = 1'b0;
`endif

  assign o_rf_addr = r_rf_addr;
  assign o_rf_we   = r_rf_we;
  assign o_acc_we  = r_acc_we;
  assign o_acc_src = r_acc_src;
  assign o_imm     = r_imm;
  assign o_alu_op  = r_alu_op;
  assign o_dm_addr = r_dm_addr;
  assign o_dm_re   = r_dm_re;
  assign o_dm_we   = r_dm_we;
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: strobes, load stall, async reset,
// run enable and illegal-instruction handling.
module tb_instr_decode;
  import op_code::*;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic [15:0]   i_instr;
  full_operation i_op;
  logic          o_pc_ce;
  logic [1:0]    o_rf_addr;
  logic          o_rf_we;
  logic          o_acc_we;
  acc_src_t      o_acc_src;
  logic [7:0]    o_imm;
  full_operation o_alu_op;
  logic [9:0]    o_dm_addr;
  logic          o_dm_re;
  logic          o_dm_we;
  logic          o_illegal;
  logic          o_halt;

  int errors = 0;
  int checks = 0;
  int pcs;

  instr_decode dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_instr   (i_instr),
    .i_op      (i_op),
    .o_pc_ce   (o_pc_ce),
    .o_rf_addr (o_rf_addr),
    .o_rf_we   (o_rf_we),
    .o_acc_we  (o_acc_we),
    .o_acc_src (o_acc_src),
    .o_imm     (o_imm),
    .o_alu_op  (o_alu_op),
    .o_dm_addr (o_dm_addr),
    .o_dm_re   (o_dm_re),
    .o_dm_we   (o_dm_we),
    .o_illegal (o_illegal),
    .o_halt    (o_halt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [15:0] w);
    i_instr = w;
    i_op    = full_operation'(w[5:2]);
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [9:0] hi,
                                     input logic [3:0] op,
                                     input logic [1:0] lo);
    return {hi, op, lo};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_rf_we"},  16'(o_rf_we),   16'h0);
    chk({tag, "_acc_we"}, 16'(o_acc_we),  16'h0);
    chk({tag, "_dm_re"},  16'(o_dm_re),   16'h0);
    chk({tag, "_dm_we"},  16'(o_dm_we),   16'h0);
    chk({tag, "_ill"},    16'(o_illegal), 16'h0);
    chk({tag, "_halt"},   16'(o_halt),    16'h0);
    chk({tag, "_alu"},    16'(o_alu_op),  16'(OP_NOP));
    chk({tag, "_src"},    16'(o_acc_src), 16'(ACC_IMM));
    chk({tag, "_imm"},    16'(o_imm),     16'h0);
    chk({tag, "_dma"},    16'(o_dm_addr), 16'h0);
    chk({tag, "_rfa"},    16'(o_rf_addr), 16'h0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_en  = 1'b1;
    put(16'h0000);
    tick();
    tick();
    chk_idle("rst");
    i_rst = 1'b0;

    put({8'hFE, 2'b10, 4'h1, 2'b00});
    chk("dld_pcce", 16'(o_pc_ce), 16'h1);
    tick();
    chk("dld_we",  16'(o_acc_we),  16'h1);
    chk("dld_src", 16'(o_acc_src), 16'(ACC_IMM));
    chk("dld_imm", 16'(o_imm),     16'hFE);

    put(mk(10'd0, 4'h2, 2'b01));
    tick();
    chk("st_we",    16'(o_rf_we),   16'h1);
    chk("st_addr",  16'(o_rf_addr), 16'h1);
    chk("st_accwe", 16'(o_acc_we),  16'h0);
    put(mk(10'd0, 4'h0, 2'b00));
    chk("nop_pcce", 16'(o_pc_ce), 16'h1);
    tick();
    chk("st_pulse", 16'(o_rf_we), 16'h0);

    put(mk(10'd10, 4'h5, 2'b00));
    tick();
    chk("stm_we",   16'(o_dm_we),   16'h1);
    chk("stm_addr", 16'(o_dm_addr), 16'd10);
    put(mk(10'd0, 4'h3, 2'b10));
    tick();
    chk("add_op",   16'(o_alu_op),  16'(OP_ADD));
    chk("add_src",  16'(o_acc_src), 16'(ACC_ALU));
    chk("add_we",   16'(o_acc_we),  16'h1);
    chk("add_rfa",  16'(o_rf_addr), 16'h2);
    chk("add_dmwe", 16'(o_dm_we),   16'h0);
    put(mk(10'd0, 4'h4, 2'b11));
    tick();
    chk("xor_op",  16'(o_alu_op),  16'(OP_XOR_BIT));
    chk("xor_rfa", 16'(o_rf_addr), 16'h3);

    // Memory-load address 20 keeps bits [7:6] at the DEFAULT_LD mode.
    pcs = 0;
    put(mk(10'd20, 4'h1, 2'b00));
    chk("mld_pc0", 16'(o_pc_ce), 16'h0);
    pcs += int'(o_pc_ce);
    tick();
    chk("mld_re",   16'(o_dm_re),   16'h1);
    chk("mld_addr", 16'(o_dm_addr), 16'd20);
    chk("mld_we1",  16'(o_acc_we),  16'h0);
    pcs += int'(o_pc_ce);
    tick();
    chk("mld_we2", 16'(o_acc_we),  16'h1);
    chk("mld_src", 16'(o_acc_src), 16'(ACC_MEM));
    chk("mld_re2", 16'(o_dm_re),   16'h0);
    chk("mld_pcs", 16'(pcs),       16'h1);

    put(mk(10'd0, 4'h3, 2'b01));
    tick();
    put(mk(10'd20, 4'h1, 2'b00));
    tick();
    chk("rmw_re", 16'(o_dm_re), 16'h1);
    #2 i_rst = 1'b1;
    #1;
    chk_idle("rmw");
    put(mk(10'd0, 4'h0, 2'b00));
    chk("rmw_dec", 16'(o_pc_ce), 16'h1);
    tick();
    i_rst = 1'b0;
    put({8'h3C, 2'b10, 4'h1, 2'b00});
    tick();
    chk("post_we",  16'(o_acc_we),  16'h1);
    chk("post_src", 16'(o_acc_src), 16'(ACC_IMM));
    chk("post_imm", 16'(o_imm),     16'h3C);

    put(mk(10'd20, 4'h1, 2'b00));
    tick();
    i_en = 1'b0;
    #1;
    chk("en_pc0", 16'(o_pc_ce), 16'h0);
    tick();
    tick();
    chk("en_hold", 16'(o_acc_we), 16'h0);
    i_en = 1'b1;
    #1;
    chk("en_pc1", 16'(o_pc_ce), 16'h1);
    tick();
    chk("en_we",  16'(o_acc_we),  16'h1);
    chk("en_src", 16'(o_acc_src), 16'(ACC_MEM));

    put(mk(10'd0, 4'hF, 2'b00));
    tick();
    chk("ill_p", 16'(o_illegal), 16'h1);
    chk("ill_s", 16'(o_acc_we),  16'h0);
    put({8'h55, 2'b10, 4'h1, 2'b00});
`ifdef ID_ILLEGAL_TRAP_EN
    chk("trap_pc", 16'(o_pc_ce), 16'h0);
    tick();
    chk("trap_ill",  16'(o_illegal), 16'h0);
    chk("trap_halt", 16'(o_halt),    16'h1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_pc", 16'(o_pc_ce),  16'h0);
      chk("halt_we", 16'(o_acc_we), 16'h0);
      tick();
    end
`else
    chk("nt_pc", 16'(o_pc_ce), 16'h1);
    tick();
    chk("nt_ill",  16'(o_illegal), 16'h0);
    chk("nt_halt", 16'(o_halt),    16'h0);
    chk("nt_imm",  16'(o_imm),     16'h55);
    put({8'h00, 2'b01, 4'h1, 2'b00});
    chk("mode_pc", 16'(o_pc_ce), 16'h1);
    tick();
    chk("mode_ill", 16'(o_illegal), 16'h1);
    chk("mode_re",  16'(o_dm_re),   16'h0);
    chk("mode_we",  16'(o_acc_we),  16'h0);
    put({8'h00, 2'b11, 4'h1, 2'b00});
    tick();
    chk("mode3_ill", 16'(o_illegal), 16'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
